// File: rtl/signed_bubble_sorter_pkg.sv
// Shared definitions for the signed bubble sorter.
// Contents:
//   DEFAULT_N - default number of entries
//   DEFAULT_W - default entry width in bits (two's complement)
//   state_t   - controller state encoding (IDLE=0, SORT=1, DONE=2)
package signed_bubble_sorter_pkg;

  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/signed_bubble_sorter_if.sv
// Load/start/result bundle between the sorter and whoever feeds it.
// Signals:
//   load_en     - write load_data into the next free entry
//   load_data   - W-bit signed value to load
//   start       - begin sorting the loaded entries
//   busy        - high while the sorter is comparing
//   done        - one-cycle pulse when the sort completes
//   count       - number of entries currently loaded
//   sorted_flat - entry i at bits [i*W +: W], entry 0 smallest
// Modports: master drives load/start, slave is the sorter side.
interface signed_bubble_sorter_if
  import signed_bubble_sorter_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int W  = DEFAULT_W,
  parameter int CW = $clog2(N + 1)
);

  logic           load_en;
  logic [W-1:0]   load_data;
  logic           start;
  logic           busy;
  logic           done;
  logic [CW-1:0]  count;
  logic [N*W-1:0] sorted_flat;

  modport master (
    output load_en, load_data, start,
    input  busy, done, count, sorted_flat
  );

  modport slave (
    input  load_en, load_data, start,
    output busy, done, count, sorted_flat
  );

endinterface

// File: rtl/signed_bubble_sorter_lt.sv
// Combinational two's-complement less-than comparator.
// Ports:
//   a  - W-bit signed operand
//   b  - W-bit signed operand
//   lt - 1 iff a < b as signed values
module signed_lt #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt
);

  assign lt = $signed(a) < $signed(b);

endmodule

// File: rtl/signed_bubble_sorter.sv
// Sequential bubble sorter with a single shared signed comparator.
// Entries are loaded one per cycle in IDLE; start sorts the loaded
// prefix in place into ascending signed order, one compare per clock,
// and done pulses for one cycle when the sort finishes.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - slave side of signed_bubble_sorter_if (load, start, status,
//           sorted_flat result)
module signed_bubble_sorter
  import signed_bubble_sorter_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  signed_bubble_sorter_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  state_t        state;
  logic [W-1:0]  entry [N];
  logic [CW-1:0] count_q;
  logic [CW-1:0] j_q;
  logic [CW-1:0] p_q;
  logic          swapped_q;
  logic          busy_q;
  logic          done_q;

  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          lt;
  logic          swapped_now;
  logic [CW-1:0] last_j;

  // Operand mux for the shared comparator: A is entry[j+1], B is entry[j].
  // A compare-decode avoids indexing the array with the wider counter.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (j_q == CW'(i)) begin
        op_b = entry[i];
        op_a = entry[i + 1];
      end
    end
  end

  signed_lt #(.W(W)) u_lt (
    .a  (op_a),
    .b  (op_b),
    .lt (lt)
  );

  // Last index of the current pass; only meaningful in SORT where
  // count >= 2 and p <= count-2, so it never underflows there.
  assign last_j      = count_q - CW'(2) - p_q;
  assign swapped_now = swapped_q | lt;

  // Controller and entry storage. busy and done are registered alongside
  // the state so they equal (state==SORT) and (state==DONE) exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      count_q   <= '0;
      j_q       <= '0;
      p_q       <= '0;
      swapped_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        entry[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          // start takes priority; a load in the same cycle is dropped
          if (bus.start) begin
            j_q       <= '0;
            p_q       <= '0;
            swapped_q <= 1'b0;
            if (count_q >= CW'(2)) begin
              state  <= ST_SORT;
              busy_q <= 1'b1;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end else if (bus.load_en && (count_q < CW'(N))) begin
            for (int i = 0; i < N; i++) begin
              if (count_q == CW'(i)) begin
                entry[i] <= bus.load_data;
              end
            end
            count_q <= count_q + CW'(1);
          end
        end

        ST_SORT: begin
          // Strict less-than means equal values stay put (stable sort)
          if (lt) begin
            for (int i = 0; i < N - 1; i++) begin
              if (j_q == CW'(i)) begin
                entry[i]     <= op_a;
                entry[i + 1] <= op_b;
              end
            end
          end
          if (j_q < last_j) begin
            j_q       <= j_q + CW'(1);
            swapped_q <= swapped_now;
          end else if ((p_q == count_q - CW'(2)) || !swapped_now) begin
            // Final pass, or a pass with no swaps means already sorted
            state     <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            swapped_q <= swapped_now;
          end else begin
            p_q       <= p_q + CW'(1);
            j_q       <= '0;
            swapped_q <= 1'b0;
          end
        end

        ST_DONE: begin
          // Entries are kept for display; only the fill pointer rewinds
          state   <= ST_IDLE;
          done_q  <= 1'b0;
          count_q <= '0;
        end

        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;

  // The result vector is the entry registers themselves
  for (genvar g = 0; g < N; g++) begin : g_flat
    assign bus.sorted_flat[g*W +: W] = entry[g];
  end

endmodule

// File: doc/signed_bubble_sorter.md
Name: signed_bubble_sorter

Overview:
- Sequential sorter that shares one W-bit signed less-than comparator across all compare steps, one compare per clock.
- Collects up to N signed words through a load port, then bubble-sorts them in place into ascending signed order on `start`.
- Raises a one-cycle `done` when the sort completes; the sorted vector is then available to downstream datapath or display logic.

Parameters:
- N, 4, max number of entries (N >= 2).
- W, 4, entry width in bits, two's-complement signed.
- CW, $clog2(N+1), width of the entry counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- load_en  input  1  write load_data into the next free entry.
- load_data  input  W  signed value to load.
- start  input  1  begin sorting the loaded entries.
- busy  output  1  high while in SORT.
- done  output  1  one-cycle pulse when the sort completes.
- count  output  CW  number of entries currently loaded.
- sorted_flat  output  N*W  entry i at bits [i*W +: W]; entry 0 is the smallest.

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-sort:
  - state=IDLE, all entries=0, count=0, busy=0, done=0, sorted_flat=0.
  - Pass and index counters are cleared.
- States: IDLE, SORT, DONE.
- IDLE:
  - load_en && count<N: entry[count]<=load_data, count<=count+1.
  - load_en && count==N: ignored, no change.
  - start && count>=2: go to SORT with pass p=0, index j=0, swapped flag=0.
  - start && count<2: go to DONE with no compares.
  - start and load_en in the same cycle: start wins, and the load is dropped.
- SORT, one compare per cycle:
  - lt = signed(entry[j+1]) < signed(entry[j]).
  - If lt, swap the two entries and set swapped. Equal values never swap, so the sort is stable.
  - If j < count-2-p: j<=j+1.
  - Else, if p==count-2 or the swapped flag (including this cycle's swap) is 0: go to DONE.
  - Else: p<=p+1, j<=0, swapped<=0.
- SORT ignores load_en and start.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - count<=0, so the next loads overwrite from entry 0.
  - Entries are not cleared; sorted_flat holds the result until it is overwritten.
- Outputs:
  - busy = (state==SORT), registered.
  - sorted_flat is the entry registers themselves.
- Entries at index >= count are neither compared nor moved.
- Latency, with start sampled in cycle t:
  - SORT occupies cycles t+1 .. t+K, where K = compare count, minimum count-1, maximum count*(count-1)/2.
  - done is high in cycle t+K+1.
  - For count<2, done is high in cycle t+1.
- Signed rule: -2^(W-1) is the minimum and 2^(W-1)-1 is the maximum. There is no overflow, because no arithmetic is done on values, only comparison.

Decomposition:
- Shared package holds:
  - State encoding typedef, 2-bit: IDLE=0, SORT=1, DONE=2.
  - Default N and W constants.
- One sub-module, signed_lt:
  - Combinational, W-bit.
  - Output 1 iff A<B as two's-complement.
  - Instantiated exactly once; muxed operands are entry[j+1] (as A) and entry[j] (as B).

Test Plan:
- Already sorted: load 1,2,3,4; start at t -> busy t+1..t+3, done at t+4, sorted_flat entries 1,2,3,4 (early exit after 3 compares).
- Reverse order: load 7,3,0,-8; start -> 6 compare cycles, done at t+7, entries -8,0,3,7.
- Duplicates and extremes: load -1,5,-1,-8 -> entries -8,-1,-1,5; separately load 7,-8,7,-8 -> -8,-8,7,7.
- Too few and too many entries:
  - Load only -3, start -> busy never high, done at t+1, entry0=-3.
  - Five loads with N=4 -> count stays 4 and the fifth value is absent.
- Interference and reset:
  - load_en and start pulsed while busy -> no effect on result or count.
  - Assert reset during SORT -> outputs zero immediately, state IDLE, count=0.
  - Reload 2,1 and start -> entries 1,2, done at t+2.
